// File: rtl/nukv_pkg.sv
// nukv_pkg: shared constants and framer state encoding for the nukv value path.
package nukv_pkg;
  localparam int NUKV_WORD_BYTES = 64;
  localparam int NUKV_LEN_LSB = 0;
  localparam int NUKV_LEN_W = 16;
  typedef enum logic [1:0] {ST_FILL, ST_DRAIN, ST_DROP} framer_st_e;
endpackage

// File: rtl/kvs_LatchedRelay.sv
// kvs_LatchedRelay: 2-entry registered skid; level lets the producer prefetch with a pipelined source.
module kvs_LatchedRelay #(
  parameter int WIDTH = 513
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [1:0]       level,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic push, pop;
  always_comb begin
    push = in_valid && cnt_q != 2'd2;
    pop = cnt_q != 2'd0 && out_ready;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    d0_d = (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? in_data : (pop ? d1_q : d0_q);
    d1_d = (push && cnt_q == 2'd1 && !pop) ? in_data : d1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
  end
  assign level = cnt_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_data = d0_q;
endmodule

// File: rtl/nukv_value_buffer.sv
// nukv_value_buffer: simple dual-port RAM with one write port and a registered read port.
module nukv_value_buffer #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/nukv_value_framer.sv
// nukv_value_framer: buffers a last-delimited value, then replays it with its byte length in word 0 [15:0].
module nukv_value_framer
  import nukv_pkg::*;
#(
  parameter int MEMORY_WIDTH = 512,
  parameter int MAX_WORDS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEMORY_WIDTH-1:0] input_data,
  input  logic                    input_valid,
  input  logic                    input_last,
  input  logic [6:0]              input_bytes,
  output logic                    input_ready,
  output logic [MEMORY_WIDTH-1:0] value_data,
  output logic                    value_valid,
  output logic                    value_last,
  input  logic                    value_ready,
  output logic                    drop_pulse
);
  localparam int AW = $clog2(MAX_WORDS);
  framer_st_e st_q, st_d;
  logic [AW:0] wcnt_q, wcnt_d, nwords_q, nwords_d, rptr_q, rptr_d;
  logic [NUKV_LEN_W-1:0] len_q, len_d;
  logic rd_v_q, rd_v_d, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
  logic drop_q, drop_d, run_q;
  logic acc, ovf, we, pop, issue;
  logic [6:0] last_bytes;
  logic [1:0] level;
  logic [MEMORY_WIDTH-1:0] rdata;
  logic [MEMORY_WIDTH:0] relay_in, relay_out;
  always_comb begin
    acc = input_valid && input_ready;
    ovf = wcnt_q == (AW+1)'(MAX_WORDS);
    we = acc && st_q == ST_FILL && !ovf;
    last_bytes = (input_bytes == 7'd0 || input_bytes > 7'(NUKV_WORD_BYTES)) ? 7'(NUKV_WORD_BYTES) : input_bytes;
    pop = value_valid && value_ready;
    // a read may issue when the skid will have room the cycle its data lands
    issue = st_q == ST_DRAIN && rptr_q < nwords_q && 3'(level) + 3'(rd_v_q) < 3'd2 + 3'(pop);
    st_d = st_q;
    wcnt_d = wcnt_q;
    nwords_d = nwords_q;
    rptr_d = rptr_q;
    len_d = len_q;
    drop_d = 1'b0;
    rd_v_d = issue;
    rd_first_d = rptr_q == '0;
    rd_last_d = rptr_q == nwords_q - 1'b1;
    unique case (st_q)
      ST_FILL: if (acc) begin
        if (ovf) begin
          st_d = input_last ? ST_FILL : ST_DROP;
          drop_d = input_last;
          wcnt_d = input_last ? '0 : wcnt_q;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (input_last) begin
            len_d = NUKV_LEN_W'(wcnt_q) * NUKV_LEN_W'(NUKV_WORD_BYTES) + NUKV_LEN_W'(last_bytes);
            nwords_d = wcnt_q + 1'b1;
            rptr_d = '0;
            st_d = ST_DRAIN;
          end
        end
      end
      ST_DROP: if (acc && input_last) begin
        drop_d = 1'b1;
        wcnt_d = '0;
        st_d = ST_FILL;
      end
      ST_DRAIN: begin
        rptr_d = issue ? rptr_q + 1'b1 : rptr_q;
        if (pop && value_last) begin
          wcnt_d = '0;
          st_d = ST_FILL;
        end
      end
      default: st_d = ST_FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_FILL;
      wcnt_q <= '0;
      nwords_q <= '0;
      rptr_q <= '0;
      len_q <= '0;
      rd_v_q <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q <= 1'b0;
      drop_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wcnt_q <= wcnt_d;
      nwords_q <= nwords_d;
      rptr_q <= rptr_d;
      len_q <= len_d;
      rd_v_q <= rd_v_d;
      rd_first_q <= rd_first_d;
      rd_last_q <= rd_last_d;
      drop_q <= drop_d;
      run_q <= 1'b1;
    end
  end
  assign input_ready = run_q && st_q != ST_DRAIN;
  assign drop_pulse = drop_q;
  // the length is muxed into word 0 on the way out; the stored word keeps its original low bits
  assign relay_in = {rd_last_q, rd_first_q ? {rdata[MEMORY_WIDTH-1:NUKV_LEN_W], len_q} : rdata};
  assign value_last = relay_out[MEMORY_WIDTH];
  assign value_data = relay_out[MEMORY_WIDTH-1:0];
  nukv_value_buffer #(.WIDTH(MEMORY_WIDTH), .DEPTH(MAX_WORDS)) u_buf (
    .clk(clk),
    .we(we),
    .waddr(wcnt_q[AW-1:0]),
    .wdata(input_data),
    .re(issue),
    .raddr(rptr_q[AW-1:0]),
    .rdata(rdata)
  );
  kvs_LatchedRelay #(.WIDTH(MEMORY_WIDTH+1)) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(rd_v_q),
    .in_data(relay_in),
    .level(level),
    .out_valid(value_valid),
    .out_ready(value_ready),
    .out_data(relay_out)
  );
endmodule

// File: tb/tb_nukv_value_framer.sv
// tb_nukv_value_framer: directed checks of framing, latency, backpressure, overflow drop and reset.
module tb_nukv_value_framer;
  logic clk = 0, rst = 1;
  logic [511:0] input_data = '0, value_data;
  logic input_valid = 0, input_last = 0, input_ready;
  logic [6:0] input_bytes = '0;
  logic value_valid, value_last, value_ready = 0, drop_pulse;
  int checks = 0, failures = 0;

  nukv_value_framer #(.MEMORY_WIDTH(512), .MAX_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .input_valid(input_valid), .input_last(input_last),
    .input_bytes(input_bytes), .input_ready(input_ready),
    .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
    .value_ready(value_ready), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(int seed, int i);
    logic [511:0] p;
    for (int j = 0; j < 16; j++) p[j*32 +: 32] = 32'(seed * 65536 + i * 256 + j) ^ 32'hA5A5_0000;
    return p;
  endfunction

  function automatic logic [511:0] exp_word(int seed, int i, int len);
    logic [511:0] p;
    p = pat(seed, i);
    if (i == 0) p[15:0] = 16'(len);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int n, int bytes, int seed);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      input_data = pat(seed, i);
      input_last = (i == n - 1);
      input_bytes = 7'(bytes);
      input_valid = 1;
      while (!input_ready && k < 200) begin
        tick();
        k++;
      end
      if (k >= 200) chk("send_timeout", 512'(input_ready), 512'(1));
      tick();
    end
    input_valid = 0;
    input_last = 0;
  endtask

  task automatic recv(int n, int len, int seed, bit bp, output int cyc);
    int idx = 0, t = 0;
    bit started = 0, stalled = 0;
    logic [511:0] hold = '0;
    cyc = 0;
    while (idx < n && t < 3000) begin
      value_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", 512'(value_valid), 512'(1));
        chk("stall_data", value_data, hold);
      end
      if (value_valid) started = 1;
      if (started) cyc++;
      if (value_valid && value_ready) begin
        chk($sformatf("data_w%0d", idx), value_data, exp_word(seed, idx, len));
        chk($sformatf("last_w%0d", idx), 512'(value_last), 512'(idx == n - 1));
        idx++;
        stalled = 0;
      end else if (value_valid) begin
        stalled = 1;
        hold = value_data;
      end else stalled = 0;
      if (bp && idx < n) chk("in_ready_drain", 512'(input_ready), 512'(0));
      tick();
      t++;
    end
    value_ready = 0;
    chk("recv_count", 512'(idx), 512'(n));
    chk("turnaround_ready", 512'(input_ready), 512'(1));
  endtask

  initial begin
    int cyc, hs, t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 512'(value_valid), 512'(0));
    chk("rst_last", 512'(value_last), 512'(0));
    chk("rst_data", value_data, 512'(0));
    chk("rst_drop", 512'(drop_pulse), 512'(0));
    chk("rst_in_ready", 512'(input_ready), 512'(0));
    rst = 0;
    tick();
    chk("in_ready_after_rst", 512'(input_ready), 512'(1));

    send(1, 10, 1);
    chk("lat_n", 512'(value_valid), 512'(0));
    tick();
    chk("lat_n1", 512'(value_valid), 512'(0));
    tick();
    chk("lat_n2", 512'(value_valid), 512'(1));
    recv(1, 10, 1, 0, cyc);

    send(3, 0, 2);
    recv(3, 192, 2, 0, cyc);
    chk("burst3_cycles", 512'(cyc), 512'(3));

    send(2, 1, 3);
    recv(2, 65, 3, 1, cyc);

    send(33, 64, 4);
    chk("ovf33_drop", 512'(drop_pulse), 512'(1));
    chk("ovf33_novalid", 512'(value_valid), 512'(0));
    tick();
    chk("ovf33_drop_once", 512'(drop_pulse), 512'(0));
    chk("ovf33_novalid2", 512'(value_valid), 512'(0));
    send(1, 64, 5);
    recv(1, 64, 5, 0, cyc);

    send(35, 20, 9);
    chk("ovf35_drop", 512'(drop_pulse), 512'(1));
    tick();
    chk("ovf35_drop_once", 512'(drop_pulse), 512'(0));
    chk("ovf35_novalid", 512'(value_valid), 512'(0));
    send(1, 100, 10);
    recv(1, 64, 10, 0, cyc);

    send(32, 64, 8);
    chk("full32_nodrop", 512'(drop_pulse), 512'(0));
    recv(32, 2048, 8, 0, cyc);
    chk("full32_cycles", 512'(cyc), 512'(32));

    send(4, 30, 6);
    value_ready = 1;
    hs = 0;
    t = 0;
    while (hs < 2 && t < 100) begin
      if (value_valid) hs++;
      tick();
      t++;
    end
    chk("mid_drain_hs", 512'(hs), 512'(2));
    chk("mid_drain_valid", 512'(value_valid), 512'(1));
    rst = 1;
    #1;
    chk("async_rst_valid", 512'(value_valid), 512'(0));
    chk("async_rst_data", value_data, 512'(0));
    chk("async_rst_ready", 512'(input_ready), 512'(0));
    value_ready = 0;
    @(posedge clk);
    #2;
    rst = 0;
    tick();
    chk("post_rst_ready", 512'(input_ready), 512'(1));
    repeat (3) tick();
    chk("post_rst_no_residual", 512'(value_valid), 512'(0));
    send(1, 5, 7);
    recv(1, 5, 7, 0, cyc);
    chk("post_rst_single_cycles", 512'(cyc), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
